// File: rtl/div_unit_pkg.sv
// Shared CPU definitions used by the divider and by EX for its stall request.
//   div_state_t       : divider FSM states (2-bit encoding)
//   DIV_WIDTH         : architectural operand width
//   DivResultReady/NotReady, DivStart/DivStop : handshake levels on ready/start
package div_unit_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BYZERO = 2'b01,
        ON     = 2'b10,
        END    = 2'b11
    } div_state_t;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU, one quotient bit per cycle.
// Feeds the HI/LO write port: remainder -> HI, quotient -> LO, ready -> write enable.
// Ports:
//   clk        : clock, rising edge
//   rst_       : asynchronous active-low reset
//   start      : divide request, held by EX until the result is consumed
//   annul      : cancel any in-flight division (priority over start)
//   signed_div : 1 = DIV (two's complement), 0 = DIVU
//   dividend   : rs operand, sampled on acceptance only
//   divisor    : rt operand, sampled on acceptance only
//   quotient   : result to LO
//   remainder  : result to HI
//   ready      : result valid
//   busy       : high in BYZERO and ON; EX stalls on it
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             start,
    input  logic             annul,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ready,
    output logic             busy
);

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return (~x) + WIDTH'(1);
    endfunction

    // 0x80..0 maps onto itself, which is its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x, input logic sd);
        return (sd && x[WIDTH-1]) ? negate(x) : x;
    endfunction

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;    // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             sd_q, sd_d;
    logic             a_neg_q, a_neg_d;
    logic             b_neg_q, b_neg_d;
    logic             ready_q, ready_d;

    // Partial remainder is WIDTH+1 bits so the trial subtraction never overflows;
    // the top bit of the difference is the borrow.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] r_step;

    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvsr_q};
    assign q_step  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    assign r_step  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvsr_d  = dvsr_q;
        sd_d    = sd_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;

        unique case (state_q)
            FREE: begin
                if (start == DivStart) begin
                    if (divisor == '0) begin
                        state_d = BYZERO;
                    end else begin
                        state_d = ON;
                        quo_d   = abs_val(dividend, signed_div);
                        dvsr_d  = abs_val(divisor, signed_div);
                        sd_d    = signed_div;
                        a_neg_d = dividend[WIDTH-1];
                        b_neg_d = divisor[WIDTH-1];
                        cnt_d   = '0;
                        rem_d   = '0;
                    end
                end
            end
            BYZERO: begin
                state_d = END;
                quo_d   = '0;
                rem_d   = '0;
            end
            ON: begin
                cnt_d = cnt_q + CNT_W'(1);
                quo_d = q_step;
                rem_d = r_step;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = END;
                    // Sign fix-up on the final iteration result.
                    if (sd_q && (a_neg_q ^ b_neg_q)) quo_d = negate(q_step);
                    if (sd_q && a_neg_q)             rem_d = negate(r_step);
                end
            end
            END: begin
                if (start == DivStop) state_d = FREE;
            end
        endcase

        if (annul) begin
            state_d = FREE;
            cnt_d   = '0;
            quo_d   = '0;
            rem_d   = '0;
        end

        // Ready asserts from the second END cycle and drops as FREE is entered.
        ready_d = (state_q == END && state_d == END) ? DivResultReady : DivResultNotReady;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= FREE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvsr_q  <= '0;
            sd_q    <= 1'b0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            ready_q <= DivResultNotReady;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvsr_q  <= dvsr_d;
            sd_q    <= sd_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            ready_q <= ready_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign ready     = ready_q;
    assign busy      = (state_q == BYZERO) || (state_q == ON);

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed and randomized divisions checked against an
// arithmetic reference model, plus annul and mid-operation reset scenarios.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_;
    logic        start;
    logic        annul;
    logic        signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        ready;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_       (rst_),
        .start      (start),
        .annul      (annul),
        .signed_div (signed_div),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .ready      (ready),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer division, truncating toward zero; /0 gives 0,0.
    task automatic model(input logic sd, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (b == 32'h0) begin
            q = 32'h0;
            r = 32'h0;
        end else if (sd) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic run_div(input string tag, input logic sd, input logic [31:0] a,
                           input logic [31:0] b);
        logic [31:0] eq, er;
        int i, nbusy, exp_lat, exp_busy;
        model(sd, a, b, eq, er);
        exp_lat  = (b == 32'h0) ? 2 : 33;
        exp_busy = (b == 32'h0) ? 1 : 32;
        start      = 1'b1;
        signed_div = sd;
        dividend   = a;
        divisor    = b;
        step();
        // Operands change after acceptance and must be ignored.
        dividend   = $urandom;
        divisor    = $urandom;
        signed_div = 1'($urandom);
        i     = 0;
        nbusy = 0;
        while (!ready && i < 60) begin
            if (busy) nbusy++;
            step();
            i++;
        end
        chk($sformatf("%s latency", tag), 32'(i), 32'(exp_lat));
        chk($sformatf("%s busy_cycles", tag), 32'(nbusy), 32'(exp_busy));
        chk($sformatf("%s quotient", tag), quotient, eq);
        chk($sformatf("%s remainder", tag), remainder, er);
        step();
        step();
        chk($sformatf("%s ready_held", tag), 32'(ready), 32'd1);
        chk($sformatf("%s quotient_held", tag), quotient, eq);
        start = 1'b0;
        step();
        chk($sformatf("%s ready_drop", tag), 32'(ready), 32'd0);
        chk($sformatf("%s busy_idle", tag), 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        logic        rsd;
        int          saw_ready;

        rst_       = 1'b0;
        start      = 1'b0;
        annul      = 1'b0;
        signed_div = 1'b0;
        dividend   = 32'h0;
        divisor    = 32'h0;
        #2;
        chk("reset quotient", quotient, 32'h0);
        chk("reset remainder", remainder, 32'h0);
        chk("reset ready", 32'(ready), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        step();
        step();
        rst_ = 1'b1;
        step();

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div("div_by_zero", 1'b1, 32'h1234_5678, 32'h0);

        // Annul during ON.
        start      = 1'b1;
        signed_div = 1'b0;
        dividend   = 32'd1000;
        divisor    = 32'd3;
        step();
        repeat (10) step();
        chk("annul busy_before", 32'(busy), 32'd1);
        annul = 1'b1;
        step();
        chk("annul busy", 32'(busy), 32'd0);
        chk("annul ready", 32'(ready), 32'd0);
        chk("annul quotient", quotient, 32'h0);
        chk("annul remainder", remainder, 32'h0);
        annul     = 1'b0;
        start     = 1'b0;
        saw_ready = 0;
        repeat (2) begin
            step();
            if (ready) saw_ready = 1;
        end
        chk("annul no_ready", 32'(saw_ready), 32'd0);
        run_div("after_annul_50_5", 1'b0, 32'd50, 32'd5);

        // Asynchronous reset during ON.
        start      = 1'b1;
        signed_div = 1'b1;
        dividend   = 32'hFFFF_CFC7;
        divisor    = 32'd7;
        step();
        repeat (10) step();
        rst_ = 1'b0;
        #1;
        chk("midreset quotient", quotient, 32'h0);
        chk("midreset remainder", remainder, 32'h0);
        chk("midreset ready", 32'(ready), 32'd0);
        chk("midreset busy", 32'(busy), 32'd0);
        start = 1'b0;
        step();
        rst_ = 1'b1;
        step();
        run_div("after_reset", 1'b1, 32'hFFFF_CFC7, 32'd7);

        // Randomized vectors.
        for (int k = 0; k < 20; k++) begin
            ra  = $urandom;
            rsd = 1'($urandom);
            case ($urandom_range(0, 4))
                0:       rb = $urandom;
                1:       rb = $urandom_range(1, 255);
                2:       rb = 32'h0;
                3:       rb = 32'($urandom) >> $urandom_range(0, 31);
                default: rb = -32'($urandom_range(1, 255));
            endcase
            run_div($sformatf("rand%0d", k), rsd, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
